// File: rtl/ranging_pkg.sv
// ranging_pkg: FSM state encoding and distance constants shared by the ranging and BCD paths
package ranging_pkg;
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
    localparam int DIST_W = 12;
    localparam int MAX_CM_DEF = 999;
endpackage

// File: rtl/ranging_sequencer_echo_sync.sv
// echo_sync: 2-FF synchroniser for the raw echo pin with single-cycle rise/fall pulses
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic rise,
    output logic fall
);
    logic meta_q, sync_q, prev_q;
    // metastability chain plus one delayed copy of the clean level for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;
endmodule

// File: rtl/ranging_sequencer.sv
// ranging_sequencer: periodic ultrasonic trigger, echo-to-centimetre timing, averaging and timeout reporting
module ranging_sequencer
    import ranging_pkg::*;
#(
    parameter int TRIG_CYCLES         = 1000,
    parameter int PERIOD_CYCLES       = 6_000_000,
    parameter int ECHO_TIMEOUT_CYCLES = 2_400_000,
    parameter int CM_DIV              = 5800,
    parameter int MAX_CM              = MAX_CM_DEF,
    parameter int AVG_LOG2            = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance,
    output logic              synch,
    output logic              err_timeout,
    output logic              busy
);
    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(ECHO_TIMEOUT_CYCLES);
    localparam int SW = $clog2(CM_DIV);
    localparam int AW = DIST_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    state_t            state_q, state_d;
    logic [PW-1:0]     period_q, period_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [SW-1:0]     sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d, sample_q, sample_d, distance_q, distance_d, cm_inc;
    logic [AW-1:0]     acc_q, acc_d, acc_n;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_n;
    logic              sample_v_q, sample_v_d, trig_q, trig_d, synch_q, synch_d;
    logic              err_q, err_d, busy_q, busy_d;
    logic              rise, fall, wrap, tmo_hit, tmo_ev;

    echo_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .echo (echo),
        .rise (rise),
        .fall (fall)
    );

    assign wrap    = sub_q == SW'(CM_DIV - 1);
    assign cm_inc  = (cm_q == DIST_W'(MAX_CM)) ? cm_q : cm_q + DIST_W'(1);
    assign tmo_hit = tmo_q == TW'(ECHO_TIMEOUT_CYCLES - 1);

    // sequencing FSM, echo-width timing in cm, and the period/timeout counters
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        cm_d       = cm_q;
        sample_d   = sample_q;
        sample_v_d = 1'b0;
        tmo_ev     = 1'b0;
        case (state_q)
            IDLE:      state_d = en ? TRIG : IDLE;
            TRIG:      state_d = (period_q == PW'(TRIG_CYCLES - 1)) ? WAIT_RISE : TRIG;
            WAIT_RISE: begin
                if (rise) begin
                    state_d = MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (tmo_hit) begin
                    state_d = HOLDOFF;
                    tmo_ev  = 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_d    = HOLDOFF;
                    sample_d   = wrap ? cm_inc : cm_q;
                    sample_v_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d = HOLDOFF;
                    tmo_ev  = 1'b1;
                end else begin
                    sub_d = wrap ? '0 : sub_q + SW'(1);
                    cm_d  = wrap ? cm_inc : cm_q;
                end
            end
            HOLDOFF:   state_d = (period_q >= PW'(PERIOD_CYCLES - 1)) ? (en ? TRIG : IDLE) : HOLDOFF;
            default:   state_d = IDLE;
        endcase
        period_d = (state_d == TRIG && state_q != TRIG) ? '0 :
                   (state_q == IDLE) ? period_q : period_q + PW'(1);
        tmo_d    = (state_d != state_q) ? '0 : tmo_q + TW'(1);
        trig_d   = state_d == TRIG;
        busy_d   = state_d != IDLE;
    end

    // sample accumulation, batch averaging and timeout reporting toward the display path
    always_comb begin
        acc_n      = acc_q + AW'(sample_q);
        cnt_n      = cnt_q + CW'(1);
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        distance_d = distance_q;
        err_d      = err_q;
        synch_d    = 1'b0;
        if (tmo_ev) begin
            acc_d      = '0;
            cnt_d      = '0;
            distance_d = DIST_W'(MAX_CM);
            err_d      = 1'b1;
            synch_d    = 1'b1;
        end else if (sample_v_q) begin
            acc_d = acc_n;
            cnt_d = cnt_n;
            if (cnt_n == CW'(1 << AVG_LOG2)) begin
                acc_d      = '0;
                cnt_d      = '0;
                distance_d = DIST_W'(acc_n >> AVG_LOG2);
                err_d      = 1'b0;
                synch_d    = 1'b1;
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            period_q   <= '0;
            tmo_q      <= '0;
            sub_q      <= '0;
            cm_q       <= '0;
            sample_q   <= '0;
            sample_v_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            distance_q <= '0;
            trig_q     <= 1'b0;
            synch_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            tmo_q      <= tmo_d;
            sub_q      <= sub_d;
            cm_q       <= cm_d;
            sample_q   <= sample_d;
            sample_v_q <= sample_v_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            distance_q <= distance_d;
            trig_q     <= trig_d;
            synch_q    <= synch_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign trig        = trig_q;
    assign distance    = distance_q;
    assign synch       = synch_q;
    assign err_timeout = err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ranging_sequencer.sv
// tb_ranging_sequencer: directed vectors for trigger timing, averaging, saturation, timeouts and enable handling
module tb_ranging_sequencer;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, echo = 1'b0;
    logic        trig, synch, err_timeout, busy;
    logic        s_trig, s_synch, s_err, s_busy;
    logic [11:0] distance, s_dist;
    int          vectors = 0, miscompares = 0;

    ranging_sequencer #(
        .TRIG_CYCLES(10), .PERIOD_CYCLES(2000), .ECHO_TIMEOUT_CYCLES(500),
        .CM_DIV(10), .MAX_CM(999), .AVG_LOG2(1)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig), .distance(distance),
        .synch(synch), .err_timeout(err_timeout), .busy(busy)
    );

    ranging_sequencer #(
        .TRIG_CYCLES(10), .PERIOD_CYCLES(2000), .ECHO_TIMEOUT_CYCLES(500),
        .CM_DIV(10), .MAX_CM(40), .AVG_LOG2(1)
    ) u_sat (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(s_trig), .distance(s_dist),
        .synch(s_synch), .err_timeout(s_err), .busy(s_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_trig(input logic v, input int lim, output int n);
        n = 0;
        while (trig !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_synch(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (synch !== 1'b1 && n < lim);
    endtask

    task automatic pulse(input int hi, input bit drop, input int exp_n,
                         input int exp_d, input int exp_sd, input int exp_e);
        int n, cnt, scnt;
        logic [11:0] d, sd;
        logic e, se;
        wait_trig(1'b1, 2100, n);
        wait_trig(1'b0, 50, n);
        chk($sformatf("start_%0d", hi), trig, 0);
        repeat (20) @(negedge clk);
        cnt = 0; scnt = 0; d = '0; sd = '0; e = 1'b0; se = 1'b0;
        for (int i = 0; i < hi + 600; i++) begin
            echo = i < hi;
            if (drop && i == hi / 2) en = 1'b0;
            @(negedge clk);
            if (synch) begin cnt++; d = distance; e = err_timeout; end
            if (s_synch) begin scnt++; sd = s_dist; se = s_err; end
        end
        echo = 1'b0;
        chk($sformatf("synchs_%0d", hi), cnt, exp_n);
        chk($sformatf("sat_synchs_%0d", hi), scnt, exp_n);
        if (exp_n != 0) begin
            chk($sformatf("dist_%0d", hi), d, exp_d);
            chk($sformatf("sat_dist_%0d", hi), sd, exp_sd);
            chk($sformatf("err_%0d", hi), e, exp_e);
            chk($sformatf("sat_err_%0d", hi), se, exp_e);
        end
    endtask

    initial begin
        int nh, ns, nr, n, cnt;
        repeat (3) @(negedge clk);
        chk("rst_trig", trig, 0);
        chk("rst_dist", distance, 0);
        chk("rst_synch", synch, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        en = 1'b1;
        wait_trig(1'b1, 10, n);
        chk("first_trig_delay", n, 1);
        for (int p = 0; p < 5; p++) begin
            wait_trig(1'b0, 50, nh);
            chk($sformatf("trig_high_%0d", p), nh, 10);
            wait_synch(700, ns);
            chk($sformatf("tmo_latency_%0d", p), ns, 500);
            chk($sformatf("tmo_dist_%0d", p), distance, 999);
            chk($sformatf("sat_tmo_dist_%0d", p), s_dist, 40);
            chk($sformatf("tmo_err_%0d", p), err_timeout, 1);
            wait_trig(1'b1, 2100, nr);
            chk($sformatf("trig_period_%0d", p), nh + ns + nr, 2000);
        end
        repeat (3) @(negedge clk);
        chk("pre_rst_trig", trig, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_trig", trig, 0);
        chk("arst_dist", distance, 0);
        chk("arst_sat_dist", s_dist, 0);
        chk("arst_synch", synch, 0);
        chk("arst_err", err_timeout, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk) rst = 1'b1;
        #1 chk("rel_trig", trig, 0);
        @(negedge clk);
        chk("restart_trig", trig, 1);
        pulse(250, 1'b0, 0, 0, 0, 0);
        pulse(350, 1'b0, 1, 30, 30, 0);
        pulse(250, 1'b0, 0, 0, 0, 0);
        pulse(0,   1'b0, 1, 999, 40, 1);
        pulse(350, 1'b0, 0, 0, 0, 0);
        pulse(450, 1'b0, 1, 40, 37, 0);
        pulse(480, 1'b0, 0, 0, 0, 0);
        pulse(250, 1'b0, 1, 36, 32, 0);
        pulse(600, 1'b0, 1, 999, 40, 1);
        pulse(500, 1'b0, 0, 0, 0, 0);
        pulse(100, 1'b0, 1, 30, 25, 0);
        pulse(300, 1'b1, 0, 0, 0, 0);
        n = 0;
        while (busy !== 1'b0 && n < 2500) begin
            @(negedge clk);
            n++;
        end
        chk("drop_busy", busy, 0);
        chk("drop_sat_busy", s_busy, 0);
        cnt = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (trig || s_trig) cnt++;
        end
        chk("drop_no_trig", cnt, 0);
        en = 1'b1;
        pulse(200, 1'b0, 1, 25, 25, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ranging_sequencer.md
Name: ranging_sequencer

Overview:
Controller that sequences the ultrasonic range sensor. It schedules trigger pulses at a fixed measurement period and times the echo pulse directly in centimetres. It averages 2^AVG_LOG2 samples, detects missing or overlong echoes, and presents a saturated distance plus a one-cycle synch strobe to the BCD/display path.

Parameters:
TRIG_CYCLES, 1000, trig high time in clk cycles (10 us @ 100 MHz)
PERIOD_CYCLES, 6_000_000, trig-rise to trig-rise measurement period (60 ms)
ECHO_TIMEOUT_CYCLES, 2_400_000, max wait for echo rise, and separately max echo high time
CM_DIV, 5800, clk cycles of echo-high per centimetre (58 us/cm)
MAX_CM, 999, saturation value of distance (3-digit display limit)
AVG_LOG2, 2, log2 of samples averaged per output (0 = no averaging)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  level; 1 = run periodic measurements
echo  in  1  raw sensor echo, asynchronous to clk
trig  out  1  sensor trigger pulse
distance  out  12  averaged distance in cm, 0..MAX_CM
synch  out  1  one-cycle strobe; distance/err_timeout updated this cycle
err_timeout  out  1  valid with synch; 1 = last batch aborted by timeout
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (rst=0, async) forces state IDLE. trig=0, distance=0, synch=0, err_timeout=0, busy=0. Accumulator, sample count, period, timeout and cm counters are all cleared.
- echo passes through a 2-FF synchroniser. Rise and fall are detected on the synchronised signal, giving 2-3 cycles of latency from the pin.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: if en=1, go to TRIG on the next cycle. The period counter clears on TRIG entry.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. The timeout counter clears.
- WAIT_RISE: wait for a synchronised echo rising edge. A level that is already high does not count.
  - Rise -> MEASURE, with the cm and sub counters cleared.
  - Timeout counter reaching ECHO_TIMEOUT_CYCLES-1 -> timeout event.
- MEASURE: while echo is high, the sub counter counts 0..CM_DIV-1. On wrap, cm increments, saturating at MAX_CM.
  - Echo fall -> sample = cm, then go to HOLDOFF.
  - Echo high for ECHO_TIMEOUT_CYCLES -> timeout event.
- Sample accept (registered, in the cycle after the fall is detected):
  - acc += sample and count++.
  - If count reaches 2^AVG_LOG2: distance = (acc incl. this sample) >> AVG_LOG2 (floor), synch=1 for one cycle, err_timeout=0, then acc and count clear.
- Timeout event: distance=MAX_CM, err_timeout=1, synch=1 for one cycle, acc and count clear, go to HOLDOFF.
- HOLDOFF: wait until the period counter reaches PERIOD_CYCLES-1.
  - Then go to TRIG if en=1, else IDLE.
  - The period counter runs from TRIG entry through HOLDOFF, so trig rises are exactly PERIOD_CYCLES apart while en stays 1.
- en=0 mid-cycle: the current measurement completes, including any synch, and the block returns to IDLE at the end of HOLDOFF. acc and count are retained, so a partial batch resumes when en returns.
- Echo glitch shorter than the synchroniser: ignored. An echo fall in WAIT_RISE or HOLDOFF: ignored.
- Echo fall and timeout in the same cycle: the fall wins, and the sample is accepted.
- Width rules:
  - acc is 12+AVG_LOG2 bits, with no overflow possible since each sample is at most MAX_CM.
  - The period and timeout counters are sized with $clog2 of their parameters.
- Outputs are registered and there are no combinational paths from input to output.

Decomposition:
- Shared package ranging_pkg holds:
  - state_t enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF)
  - the MAX_CM default and the 12-bit distance width constant, shared with BCD.
- One sub-module, echo_sync: 2-FF synchroniser with rise/fall pulse outputs, using the same clk and rst.

Test Plan:
Sim parameters are TRIG=10, PERIOD=2000, TIMEOUT=500, CM_DIV=10, AVG_LOG2=1.
- Reset while en=1 and trig high: trig drops immediately, all outputs are 0, and a new trig rises on the 2nd cycle after rst releases.
- Single-period timing, en=1: trig is high exactly 10 cycles, and rising edges are exactly 2000 cycles apart over 5 periods.
- Averaging: echo high 250 cycles then 350 cycles (25 cm, 35 cm) -> one synch after the second fall, distance=30, err_timeout=0. No synch after the first sample.
- No echo: echo held 0 -> synch 500 cycles after trig falls (plus pipeline latency), distance=999, err_timeout=1, accumulator cleared.
- Saturation / overlong echo: echo high 480 cycles (48 cm) with MAX_CM=40 -> sample 40. Echo high 600 cycles -> timeout, distance=MAX_CM, err_timeout=1.
- en drops during MEASURE: the current sample completes, no further trig, busy=0 after HOLDOFF. Re-assert en and send one sample of 20 cm after a prior held 30 cm -> distance=25.
